// File: rtl/mips_pkg.sv
// Shared types and constants for the M-stage data-memory access path.
package mips_pkg;

    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_ADDR_W = 32;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// REQ-state watchdog: counts wait cycles and flags when the limit is reached.
module dmem_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;

    logic [CNT_W-1:0] cnt_q;

    // Clear on REQ entry, count each REQ cycle that has no ready
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory access sequencer: IDLE -> REQ -> DONE with pipeline stall.
// Optional REQ timeout (BusErr) is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] AluoutM,
    input  logic [DATA_W-1:0] writeDataM,
    input  logic              MemwriteM,
    input  logic              MemtoRegM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              AdErr,
    output logic              BusErr
);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ad_err_q, ad_err_d;
    logic              bus_err_q, bus_err_d;
    logic              pend;
    logic              misaligned;
    logic              timeout_hit;

    assign pend       = MemwriteM | MemtoRegM;
    assign misaligned = is_misaligned(AluoutM[1:0]);

`ifdef DMEM_TIMEOUT_EN
    logic cnt_clr;
    logic cnt_en;
    logic cnt_expired;

    assign cnt_clr = (state_q == IDLE) & pend & ~misaligned;
    assign cnt_en  = (state_q == REQ) & ~mem_ready;

    dmem_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk     (clk),
        .Rst     (Rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    assign timeout_hit = cnt_expired;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ad_err_d  = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend) begin
                    if (misaligned) begin
                        ad_err_d = 1'b1;
                        rdata_d  = '0;
                        state_d  = DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = MemwriteM;  // write wins if both are set
                        addr_d  = {AluoutM[ADDR_W-1:2], 2'b00};
                        wdata_d = writeDataM;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Ready beats an expiry in the same cycle
                if (mem_ready) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ad_err_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ad_err_q  <= ad_err_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ReadDataM = rdata_q;
    assign AdErr     = ad_err_q;
    assign BusErr    = bus_err_q;
    assign StallM    = pend & (state_q != DONE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl; scoreboard of expected memory transactions.
module tb_dmem_access_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TO_CYC = 8;
`else
    localparam int unsigned TO_CYC = 255;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] AluoutM = '0;
    logic [31:0] writeDataM = '0;
    logic        MemwriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        AdErr;
    logic        BusErr;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];
    logic [31:0] rd_model = '0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .AluoutM    (AluoutM),
        .writeDataM (writeDataM),
        .MemwriteM  (MemwriteM),
        .MemtoRegM  (MemtoRegM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .AdErr      (AdErr),
        .BusErr     (BusErr)
    );

    // Scoreboard: every completed handshake must match the oldest expected transaction
    always @(negedge clk) begin
        if (!Rst && mem_req && mem_ready) begin
            txn_t obs, exp_t;
            obs = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h expected no transaction", obs);
            end else begin
                exp_t = exp_q.pop_front();
                if (obs !== exp_t) begin
                    errors++;
                    $display("FAIL sb_txn: got %h expected %h", obs, exp_t);
                end
            end
        end
    end

    // Drive one M-stage instruction until its DONE cycle; waits<0 means never ready
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdv, input int waits,
                          output int stall_n, output int req_n, output int ad_n,
                          output int bus_n, output bit stable, output bit done_ok,
                          output logic [31:0] rd_done);
        txn_t first;
        AluoutM    = addr;
        writeDataM = wd;
        MemwriteM  = wr;
        MemtoRegM  = rd;
        mem_ready  = 1'b0;
        stall_n = 0; req_n = 0; ad_n = 0; bus_n = 0;
        stable = 1'b1; done_ok = 1'b0; rd_done = '0;
        first = '0;
        for (int c = 0; c < 400; c++) begin
            #1;
            if (StallM) stall_n++;
            if (AdErr) ad_n++;
            if (BusErr) bus_n++;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) first = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
                else if (first !== txn_t'{addr: mem_addr, we: mem_we, wdata: mem_wdata})
                    stable = 1'b0;
                mem_ready = (waits >= 0) && (req_n == waits + 1);
                mem_rdata = mem_ready ? rdv : 32'hDEAD_0000 + 32'(c);
            end else begin
                mem_ready = 1'b0;
            end
            if (!StallM) begin
                done_ok = 1'b1;
                rd_done = ReadDataM;
                break;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic go_idle();
        MemwriteM = 1'b0;
        MemtoRegM = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_req, mem_we, AdErr, BusErr, StallM} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 00000", {mem_req, mem_we, AdErr, BusErr, StallM});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h/%h expected 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (ReadDataM !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", ReadDataM);
        end
    endtask

    task automatic test_load_fast();
        int s, r, a, b; bit st, dn; logic [31:0] rdd;
        exp_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
        access(1'b0, 1'b1, 32'h100, 32'h0, 32'hCAFEF00D, 0, s, r, a, b, st, dn, rdd);
        rd_model = 32'hCAFEF00D;
        checks++;
        if (!dn || s != 2 || r != 1) begin
            errors++;
            $display("FAIL load_fast_timing: got done=%0d stall=%0d req=%0d expected 1/2/1", dn, s, r);
        end
        checks++;
        if (rdd !== rd_model) begin
            errors++;
            $display("FAIL load_fast_rdata: got %h expected %h", rdd, rd_model);
        end
        go_idle();
    endtask

    task automatic test_store_wait();
        int s, r, a, b; bit st, dn; logic [31:0] rdd;
        exp_q.push_back('{addr: 32'h24, we: 1'b1, wdata: 32'h12345678});
        access(1'b1, 1'b0, 32'h24, 32'h12345678, 32'h5555AAAA, 4, s, r, a, b, st, dn, rdd);
        checks++;
        if (!dn || s != 6 || r != 5 || !st) begin
            errors++;
            $display("FAIL store_wait: got done=%0d stall=%0d req=%0d stable=%0d expected 1/6/5/1",
                     dn, s, r, st);
        end
        checks++;
        if (rdd !== rd_model) begin
            errors++;
            $display("FAIL store_rdata_hold: got %h expected %h", rdd, rd_model);
        end
        go_idle();
    endtask

    task automatic test_misaligned();
        int s, r, a, b; bit st, dn; logic [31:0] rdd;
        access(1'b0, 1'b1, 32'h102, 32'h0, 32'h77777777, 0, s, r, a, b, st, dn, rdd);
        rd_model = 32'h0;
        MemtoRegM = 1'b0;
        #1;
        checks++;
        if (!dn || r != 0 || a != 1 || s != 1 || AdErr !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: got done=%0d req=%0d aderr=%0d stall=%0d aderr_after=%b expected 1/0/1/1/0",
                     dn, r, a, s, AdErr);
        end
        checks++;
        if (rdd !== rd_model) begin
            errors++;
            $display("FAIL misaligned_rdata: got %h expected %h", rdd, rd_model);
        end
        go_idle();
    endtask

    task automatic test_both_set();
        int s, r, a, b; bit st, dn; logic [31:0] rdd;
        // seed a known ReadDataM first
        exp_q.push_back('{addr: 32'h80, we: 1'b0, wdata: 32'h0});
        access(1'b0, 1'b1, 32'h80, 32'h0, 32'h13579BDF, 1, s, r, a, b, st, dn, rdd);
        rd_model = 32'h13579BDF;
        go_idle();
        exp_q.push_back('{addr: 32'h40, we: 1'b1, wdata: 32'h0000A5A5});
        access(1'b1, 1'b1, 32'h43 & ~32'h3, 32'h0000A5A5, 32'hFFFF0000, 1, s, r, a, b, st, dn, rdd);
        checks++;
        if (!dn || rdd !== rd_model) begin
            errors++;
            $display("FAIL both_set_rdata: got done=%0d %h expected 1 %h", dn, rdd, rd_model);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int s1, s2, r1, r2, a, b; bit st, d1, d2; logic [31:0] rd1, rd2;
        exp_q.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
        exp_q.push_back('{addr: 32'h204, we: 1'b1, wdata: 32'hFEEDFACE});
        access(1'b0, 1'b1, 32'h200, 32'h0, 32'h0BADBEEF, 0, s1, r1, a, b, st, d1, rd1);
        access(1'b1, 1'b0, 32'h204, 32'hFEEDFACE, 32'h0, 0, s2, r2, a, b, st, d2, rd2);
        rd_model = 32'h0BADBEEF;
        checks++;
        if (!d1 || !d2 || (s1 + 1) + (s2 + 1) != 6 || r1 != 1 || r2 != 1) begin
            errors++;
            $display("FAIL back_to_back: got cycles=%0d req=%0d/%0d expected 6 1/1",
                     (s1 + 1) + (s2 + 1), r1, r2);
        end
        checks++;
        if (rd1 !== rd_model || rd2 !== rd_model) begin
            errors++;
            $display("FAIL back_to_back_rdata: got %h/%h expected %h", rd1, rd2, rd_model);
        end
        go_idle();
    endtask

    task automatic test_ignore_ready();
        mem_ready = 1'b1;
        mem_rdata = 32'h99999999;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== rd_model) begin
            errors++;
            $display("FAIL ignore_ready: got req=%b stall=%b rdata=%h expected 0 0 %h",
                     mem_req, StallM, ReadDataM, rd_model);
        end
        mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        AluoutM   = 32'h300;
        MemtoRegM = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got req=%b expected 1", mem_req);
        end
        Rst = 1'b1;
        #1;
        rd_model = 32'h0;
        checks++;
        if (mem_req !== 1'b0 || AdErr !== 1'b0 || BusErr !== 1'b0 || StallM !== 1'b1
            || ReadDataM !== rd_model) begin
            errors++;
            $display("FAIL reset_mid: got req=%b ad=%b bus=%b stall=%b rdata=%h expected 0 0 0 1 0",
                     mem_req, AdErr, BusErr, StallM, ReadDataM);
        end
        @(posedge clk); #1;
        Rst = 1'b0;
        MemtoRegM = 1'b0;
        #1;
        checks++;
        if (StallM !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: got stall=%b req=%b expected 0 0", StallM, mem_req);
        end
        @(posedge clk); #1;
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int s, r, a, b; bit st, dn; logic [31:0] rdd;
        // nonzero ReadDataM so the timeout clear is observable
        exp_q.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0});
        access(1'b0, 1'b1, 32'h500, 32'h0, 32'h24681357, 0, s, r, a, b, st, dn, rdd);
        go_idle();
        access(1'b0, 1'b1, 32'h504, 32'h0, 32'h0, -1, s, r, a, b, st, dn, rdd);
        rd_model = 32'h0;
        checks++;
        if (!dn || r != 8 || b != 1 || rdd !== rd_model) begin
            errors++;
            $display("FAIL timeout: got done=%0d req=%0d buserr=%0d rdata=%h expected 1/8/1/0",
                     dn, r, b, rdd);
        end
        go_idle();
        exp_q.push_back('{addr: 32'h508, we: 1'b0, wdata: 32'h0});
        access(1'b0, 1'b1, 32'h508, 32'h0, 32'h600DCAFE, 7, s, r, a, b, st, dn, rdd);
        rd_model = 32'h600DCAFE;
        checks++;
        if (!dn || r != 8 || b != 0 || rdd !== rd_model) begin
            errors++;
            $display("FAIL timeout_ready_wins: got done=%0d req=%0d buserr=%0d rdata=%h expected 1/8/0/%h",
                     dn, r, b, rdd, rd_model);
        end
        go_idle();
    endtask
`endif

    initial begin
        @(posedge clk); #1;
        test_reset();
        Rst = 1'b0;
        @(posedge clk); #1;
        test_load_fast();
        test_store_wait();
        test_misaligned();
        test_both_set();
        test_back_to_back();
        test_ignore_ready();
        test_reset_mid();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the M stage of the pipelined MIPS core.
- Sits between the EX/MEM pipeline register outputs (AluoutM, writeDataM, MemwriteM, MemtoRegM) and a variable-latency data memory with a req/ready handshake.
- Freezes the pipeline via StallM until the access completes, then presents the read data to the MEM/WB register.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address width.
- TIMEOUT_CYC, 255, maximum REQ-state cycles before abort (only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- AluoutM  input  ADDR_W  byte address from the M stage.
- writeDataM  input  DATA_W  store data.
- MemwriteM  input  1  store request.
- MemtoRegM  input  1  load request.
- mem_req  output  1  memory request, registered.
- mem_we  output  1  1 = write, registered.
- mem_addr  output  ADDR_W  registered word address (byte address with [1:0] forced to 0).
- mem_wdata  output  DATA_W  registered store data.
- mem_ready  input  1  memory completes the access this cycle.
- mem_rdata  input  DATA_W  load data, valid when mem_ready=1.
- ReadDataM  output  DATA_W  captured load data.
- StallM  output  1  freeze IF/ID, ID/EX and EX/MEM registers and the PC.
- AdErr  output  1  one-cycle pulse: misaligned access.
- BusErr  output  1  one-cycle pulse: timeout (optional feature only; otherwise tied to 0).

Behaviour:
- Reset values (asynchronous, Rst=1): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, AdErr=0, BusErr=0, timeout counter=0.
- Definitions:
  - pend = MemwriteM | MemtoRegM.
  - StallM = pend & (state != DONE). StallM is combinational.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If pend and AluoutM[1:0] == 0: latch mem_addr, mem_wdata and mem_we = MemwriteM; set mem_req=1; go to REQ.
  - If pend and AluoutM[1:0] != 0: no memory access; pulse AdErr; ReadDataM=0; go to DONE.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req and the address/data/we outputs stay stable until mem_ready is sampled 1.
  - On mem_ready: mem_req=0; if load, ReadDataM <= mem_rdata; go to DONE.
  - A mem_ready that arrives while not in REQ is ignored.
- DONE:
  - StallM=0 for exactly one cycle so the pipeline advances.
  - Next state is unconditionally IDLE, so back-to-back memory instructions each take a full sequence.
- Latency: minimum 3 cycles per access (IDLE detect, REQ with immediate ready, DONE advance); each extra wait cycle adds 1.
- If MemwriteM and MemtoRegM are both 1 (illegal): the write wins and ReadDataM is unchanged.
- ReadDataM holds its last value between loads; stores do not modify it.
- Reset mid-access: mem_req drops asynchronously; the in-flight access is abandoned and no error is raised.
- Non-memory instructions never stall (pend=0 gives StallM=0).

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without mem_ready.
  - When the count reaches TIMEOUT_CYC-1 with no ready: mem_req=0, BusErr pulses one cycle, ReadDataM=0, go to DONE.
  - mem_ready on the same cycle as expiry takes priority; no BusErr.
- Undefined: no counter; REQ waits indefinitely; BusErr is constant 0.

Decomposition:
- Shared package mips_pkg holds:
  - the state enum (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - the DATA_W/ADDR_W defaults;
  - the ALIGN_MASK constant 2'b11.
- One natural sub-module, dmem_timeout_cnt: counter with clear, enable and expired flag, instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Load, ready on first REQ cycle: AluoutM=0x100, MemtoRegM=1, mem_rdata=0xCAFEF00D.
  - Expect mem_req high 1 cycle with mem_addr=0x100 and mem_we=0.
  - Expect StallM high 2 cycles, ReadDataM=0xCAFEF00D in DONE.
- Store with 4 wait cycles: AluoutM=0x24, writeDataM=0x12345678, MemwriteM=1.
  - Expect mem_req/mem_we/mem_wdata stable for 5 cycles and StallM high 6 cycles.
  - Expect ReadDataM unchanged.
- Misaligned load: AluoutM=0x102, MemtoRegM=1.
  - Expect mem_req never asserted, AdErr one-cycle pulse, StallM high 1 cycle, ReadDataM=0.
- Back-to-back load then store, both with immediate ready.
  - Expect two complete IDLE→REQ→DONE sequences (6 cycles total) with exactly one DONE per instruction.
- Rst asserted in REQ cycle 2 of a pending load.
  - Expect mem_req=0 and state IDLE immediately; no AdErr/BusErr; StallM follows pend after release.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYC=8, mem_ready held 0.
  - Expect BusErr pulse after 8 REQ cycles, ReadDataM=0, then DONE.
  - Repeat with mem_ready on cycle 8: expect no BusErr.
